phase_report_sched: RTL and testbench
=====================================

PHASE_REPORT_SCHED -- requirements
Module: phase_report_sched

Interface
REQ-001 Parameter P_HDR, default 8'hA5, frame header byte.
REQ-002 Parameter P_FRAME_LEN, default 23, bytes per frame; fixed by the frame format, not user-tunable.
REQ-003 i_lclk  in  1  50MHz system clock; the only clock; all logic on rising edge.
REQ-004 i_res_n  in  1  reset; synchronous and active-low; sampled on i_lclk rising edge.
REQ-005 i_ph_en  in  1  one-cycle strobe; i_ph1..i_ph5 valid in the same cycle.
REQ-006 i_ph1..i_ph5  in  30 each  phase results; unsigned; 1 LSB = 1ns; modulo 2^30.
REQ-007 o_tx_data  out  8  frame byte toward the UART TX.
REQ-008 o_tx_valid  out  1  o_tx_data valid.
REQ-009 i_tx_ready  in  1  sink accepts the byte when high together with o_tx_valid.
REQ-010 o_busy  out  1  high in any state other than IDLE.
REQ-011 o_seq  out  8  sequence number of the last frame started.
REQ-012 o_drop_cnt  out  8  count of strobes dropped while busy; saturating.

Function
REQ-013 FSM states: IDLE, CALC, SEND; encoding is free.
REQ-014 IDLE: on i_ph_en=1, latch i_ph1..i_ph5 and go to CALC.
REQ-015 CALC lasts exactly 1 cycle; it computes the relative phases, increments the sequence register and goes to SEND.
REQ-016 Relative phase: d_k = (ph_k - ph1) mod 2^30 for k=2..5; interpreted as 30-bit two's complement; sign-extended to 32 bits.
REQ-017 Sequence register is 8 bits and wraps 255->0; the frame carries the post-increment value; o_seq equals that value from CALC onward.
REQ-018 Frame byte order, with all multi-byte fields MSB first:
- P_HDR
- seq
- ph1 zero-extended to 32 bits (4 bytes)
- d2, d3, d4, d5 (4 bytes each)
- checksum
REQ-019 Checksum = XOR of bytes 0..21 of the frame.
REQ-020 Latency: i_ph_en at cycle T -> CALC at T+1 -> o_tx_valid=1 with P_HDR at T+2.
REQ-021 Handshake: a byte transfers on a cycle where o_tx_valid & i_tx_ready = 1.
REQ-022 While o_tx_valid=1 and i_tx_ready=0, o_tx_data holds stable and o_tx_valid stays high.
REQ-023 After a transfer, the next byte is presented in the following cycle; o_tx_valid stays high, so back-to-back throughput is 1 byte per cycle.
REQ-024 After byte 22 transfers, go to IDLE; o_tx_valid=0 in the next cycle.
REQ-025 o_tx_valid SHALL be 0 in IDLE and CALC.
REQ-026 i_ph_en in CALC or SEND: ignore the data; increment o_drop_cnt unless it is 255.
REQ-027 This includes i_ph_en in the same cycle as the last byte's transfer; that strobe is dropped.
REQ-028 i_ph_en in the first IDLE cycle after a frame SHALL be accepted.
REQ-029 Latched values SHALL NOT change during CALC or SEND, whatever i_ph1..i_ph5 do.
REQ-030 i_ph_en held high for several cycles: the first cycle is the accepted strobe; each further high cycle while busy counts as a drop.

Reset
REQ-031 While i_res_n=0 at a clock edge, on that edge the block SHALL force:
- FSM = IDLE
- o_tx_valid = 0, o_tx_data = 0, o_busy = 0
- o_seq = 0, o_drop_cnt = 0
- latched values = 0, byte index = 0
REQ-032 Reset mid-frame: the frame is abandoned and o_tx_valid=0 from the reset edge; there is no resume after reset release.
REQ-033 The first strobe after reset release produces a frame with seq=1.

Verification
REQ-034 Basic frame: ph1=1000, ph2=1010, ph3=990, ph4=1000, ph5=0x3FFFFFFF, ready tied 1 -> bytes:
- A5, 01
- 00 00 03 E8
- 00 00 00 0A
- FF FF FF F6
- 00 00 00 00
- FF FF FC 17
- checksum = XOR of the above
The bytes come on 23 consecutive cycles starting at T+2.
REQ-035 Wrap: ph1=0x3FFFFFF0, ph2=0x00000010 -> d2 = 00 00 00 20.
REQ-036 Backpressure: i_tx_ready random at 30% duty -> bench confirms:
- byte stream identical to the ready=1 case
- o_tx_data stable while stalled
- no byte lost or duplicated
REQ-037 Drop: strobe during SEND, then strobe on the last-byte transfer cycle -> o_drop_cnt=2 and one frame only; strobe in the next IDLE cycle -> frame with seq=2.
REQ-038 Saturation/wrap: 300 drops -> o_drop_cnt=255; 256 frames -> seq sequence 1..255 then 0.
REQ-039 Reset mid-frame: i_res_n=0 for 1 cycle at byte 10 -> o_tx_valid=0 and o_seq=0 from that edge; the next strobe sends a full frame with seq=1.

Source files
------------

// File: rtl/phase_report_sched.sv
// Phase report scheduler: latches five 30-bit phase results on a strobe and
// streams them as a 23-byte checksummed frame through a valid/ready byte port.
module phase_report_sched #(
    parameter logic [7:0] P_HDR       = 8'hA5,
    parameter int         P_FRAME_LEN = 23
) (
    input  logic        i_lclk,
    input  logic        i_res_n,
    input  logic        i_ph_en,
    input  logic [29:0] i_ph1,
    input  logic [29:0] i_ph2,
    input  logic [29:0] i_ph3,
    input  logic [29:0] i_ph4,
    input  logic [29:0] i_ph5,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic [7:0]  o_seq,
    output logic [7:0]  o_drop_cnt
);

    localparam int LAST = P_FRAME_LEN - 1;

    typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

    state_t state, state_next;

    logic        [29:0] ph1_p0, ph2_p0, ph3_p0, ph4_p0, ph5_p0;
    logic signed [31:0] d2_p1, d3_p1, d4_p1, d5_p1;
    logic        [7:0]  seq, drop_cnt, chk;
    logic        [4:0]  idx;
    logic        [4:0]  off;
    logic        [31:0] word;
    logic        [7:0]  frame_byte;

    // Wrapped 30-bit difference read as two's complement, then sign-extended.
    function automatic logic signed [31:0] rel_phase(input logic [29:0] ph,
                                                     input logic [29:0] ref_ph);
        logic signed [29:0] diff;
        diff = signed'(ph - ref_ph);
        return {{2{diff[29]}}, diff};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge i_lclk) begin
        if (!i_res_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_tx_valid = 1'b0;
        o_busy     = 1'b1;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_ph_en) state_next = CALC;
            end
            CALC: state_next = SEND;
            SEND: begin
                o_tx_valid = 1'b1;
                if (i_tx_ready && idx == 5'(LAST)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bytes 2..21 are four-byte words, MSB first; header, seq and checksum are special.
    always_comb begin
        off  = idx - 5'd2;
        word = {2'b00, ph1_p0};
        case (off[4:2])
            3'd0:    word = {2'b00, ph1_p0};
            3'd1:    word = d2_p1;
            3'd2:    word = d3_p1;
            3'd3:    word = d4_p1;
            default: word = d5_p1;
        endcase
        case (off[1:0])
            2'd0:    frame_byte = word[31:24];
            2'd1:    frame_byte = word[23:16];
            2'd2:    frame_byte = word[15:8];
            default: frame_byte = word[7:0];
        endcase
        if (idx == 5'd0)          frame_byte = P_HDR;
        else if (idx == 5'd1)     frame_byte = seq;
        else if (idx == 5'(LAST)) frame_byte = chk;
        o_tx_data = (state == SEND) ? frame_byte : 8'h00;
    end

    // The sequence number advances on acceptance so o_seq already shows the
    // new value during CALC.
    always_ff @(posedge i_lclk) begin
        if (!i_res_n) begin
            ph1_p0   <= '0;
            ph2_p0   <= '0;
            ph3_p0   <= '0;
            ph4_p0   <= '0;
            ph5_p0   <= '0;
            d2_p1    <= '0;
            d3_p1    <= '0;
            d4_p1    <= '0;
            d5_p1    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            chk      <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_ph_en) begin
                        ph1_p0 <= i_ph1;
                        ph2_p0 <= i_ph2;
                        ph3_p0 <= i_ph3;
                        ph4_p0 <= i_ph4;
                        ph5_p0 <= i_ph5;
                        seq    <= seq + 8'd1;
                    end
                end
                // ---- stage p1: relative phases ----
                CALC: begin
                    d2_p1 <= rel_phase(ph2_p0, ph1_p0);
                    d3_p1 <= rel_phase(ph3_p0, ph1_p0);
                    d4_p1 <= rel_phase(ph4_p0, ph1_p0);
                    d5_p1 <= rel_phase(ph5_p0, ph1_p0);
                    chk   <= '0;
                    idx   <= '0;
                end
                // ---- send: checksum accumulates over transferred bytes ----
                SEND: begin
                    if (i_tx_ready) begin
                        chk <= chk ^ frame_byte;
                        idx <= (idx == 5'(LAST)) ? 5'd0 : idx + 5'd1;
                    end
                end
                default: ;
            endcase
            if (i_ph_en && state != IDLE) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign o_seq      = seq;
    assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_phase_report_sched.sv
// Directed bench for phase_report_sched: frame content, latency, backpressure,
// drop counting, sequence wrap and mid-frame reset.
`timescale 1ns/1ps
module tb_phase_report_sched;

    typedef logic [7:0]  frame_t [23];
    typedef logic [29:0] ph_t [5];

    logic        clk = 1'b0;
    logic        i_res_n, i_ph_en, i_tx_ready;
    logic [29:0] i_ph1, i_ph2, i_ph3, i_ph4, i_ph5;
    logic [7:0]  o_tx_data, o_seq, o_drop_cnt;
    logic        o_tx_valid, o_busy;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    phase_report_sched dut (
        .i_lclk(clk), .i_res_n(i_res_n), .i_ph_en(i_ph_en),
        .i_ph1(i_ph1), .i_ph2(i_ph2), .i_ph3(i_ph3), .i_ph4(i_ph4), .i_ph5(i_ph5),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_seq(o_seq), .o_drop_cnt(o_drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame built from arithmetic on signed integers.
    function automatic void make_frame(input logic [7:0] s, input ph_t p, output frame_t f);
        logic [31:0] w [5];
        longint diff;
        logic [7:0] c;
        w[0] = {2'b00, p[0]};
        for (int k = 1; k < 5; k++) begin
            diff = longint'(p[k]) - longint'(p[0]);
            if (diff >= 64'sd536870912) diff = diff - 64'sd1073741824;
            else if (diff < -64'sd536870912) diff = diff + 64'sd1073741824;
            w[k] = 32'(diff);
        end
        f[0] = 8'hA5;
        f[1] = s;
        for (int i = 0; i < 5; i++)
            for (int b = 0; b < 4; b++)
                f[2 + 4*i + b] = 8'(w[i] >> (24 - 8*b));
        c = 8'h00;
        for (int i = 0; i < 22; i++) c = c ^ f[i];
        f[22] = c;
    endfunction

    task automatic strobe(input ph_t p);
        i_ph1 = p[0]; i_ph2 = p[1]; i_ph3 = p[2]; i_ph4 = p[3]; i_ph5 = p[4];
        i_ph_en = 1'b1;
        tick();
        i_ph_en = 1'b0;
    endtask

    // Consumes bytes until stop_at transfers; strobes on transfers number sa/sb.
    task automatic recv_frame(input frame_t want, input int duty, input int sa, input int sb,
                              input int stop_at, input string tag,
                              output frame_t got, output int cycles);
        int n;
        logic stalled;
        logic [7:0] held;
        n = 0; stalled = 1'b0; held = 8'h00; cycles = 0;
        for (int i = 0; i < 23; i++) got[i] = 8'h00;
        while (n < stop_at && cycles < 600) begin
            if (stalled) begin
                check($sformatf("%s stall_valid", tag), o_tx_valid, 1'b1);
                check($sformatf("%s stall_data", tag), o_tx_data, held);
            end
            i_tx_ready = (int'($urandom_range(0, 99)) < duty);
            i_ph1 = 30'($urandom()); i_ph2 = 30'($urandom()); i_ph3 = 30'($urandom());
            i_ph4 = 30'($urandom()); i_ph5 = 30'($urandom());
            i_ph_en = o_tx_valid && i_tx_ready && (n == sa || n == sb);
            if (o_tx_valid && i_tx_ready) begin
                check($sformatf("%s byte%0d", tag, n), o_tx_data, want[n]);
                got[n] = o_tx_data;
                n++;
                stalled = 1'b0;
            end else begin
                stalled = o_tx_valid;
                held = o_tx_data;
            end
            tick();
            cycles++;
        end
        i_ph_en = 1'b0;
        i_tx_ready = 1'b1;
        check($sformatf("%s count", tag), n, stop_at);
    endtask

    initial begin
        ph_t p;
        frame_t basic, want, got;
        logic [7:0] exp_seq;
        int cyc;

        i_res_n = 1'b0; i_ph_en = 1'b0; i_tx_ready = 1'b1;
        i_ph1 = '0; i_ph2 = '0; i_ph3 = '0; i_ph4 = '0; i_ph5 = '0;
        tick(); tick();
        check("rst_valid", o_tx_valid, 1'b0);
        check("rst_data", o_tx_data, 8'h00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_seq", o_seq, 8'h00);
        check("rst_drop", o_drop_cnt, 8'h00);
        i_res_n = 1'b1;
        exp_seq = 8'd0;
        tick();

        // Basic frame with ready tied high.
        p = '{30'd1000, 30'd1010, 30'd990, 30'd1000, 30'h3FFFFFFF};
        basic = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h00, 8'h00, 8'h00, 8'h0A,
                  8'hFF, 8'hFF, 8'hFF, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'hFC, 8'h17, 8'hA7};
        strobe(p);
        exp_seq = exp_seq + 8'd1;
        check("calc_busy", o_busy, 1'b1);
        check("calc_valid", o_tx_valid, 1'b0);
        check("calc_seq", o_seq, exp_seq);
        tick();
        check("first_valid", o_tx_valid, 1'b1);
        check("first_byte", o_tx_data, 8'hA5);
        recv_frame(basic, 100, -1, -1, 23, "basic", got, cyc);
        check("basic_cycles", cyc, 23);
        check("basic_end_valid", o_tx_valid, 1'b0);
        check("basic_end_busy", o_busy, 1'b0);

        // Wrapped relative phase.
        p = '{30'h3FFFFFF0, 30'h00000010, 30'h3FFFFFF0, 30'h3FFFFFF0, 30'h3FFFFFF0};
        exp_seq = exp_seq + 8'd1;
        make_frame(exp_seq, p, want);
        strobe(p);
        recv_frame(want, 100, -1, -1, 23, "wrap", got, cyc);
        check("wrap_d2", {got[6], got[7], got[8], got[9]}, 32'h00000020);

        // Backpressure at 30% ready: same bytes as basic except seq and checksum.
        p = '{30'd1000, 30'd1010, 30'd990, 30'd1000, 30'h3FFFFFFF};
        exp_seq = exp_seq + 8'd1;
        want = basic;
        want[1] = exp_seq;
        want[22] = basic[22] ^ 8'h01 ^ exp_seq;
        strobe(p);
        recv_frame(want, 30, -1, -1, 23, "bp", got, cyc);
        check("bp_end_valid", o_tx_valid, 1'b0);

        // Drops: strobe mid-frame and on the final transfer.
        i_res_n = 1'b0; tick(); i_res_n = 1'b1; exp_seq = 8'd0;
        p = '{30'd5, 30'd7, 30'd3, 30'h20000000, 30'h1FFFFFFF};
        exp_seq = exp_seq + 8'd1;
        make_frame(exp_seq, p, want);
        strobe(p);
        recv_frame(want, 100, 5, 22, 23, "drop", got, cyc);
        check("drop_cnt2", o_drop_cnt, 8'd2);
        check("drop_one_frame", o_busy, 1'b0);
        check("drop_idle_valid", o_tx_valid, 1'b0);
        exp_seq = exp_seq + 8'd1;
        make_frame(exp_seq, p, want);
        strobe(p);
        check("drop_next_busy", o_busy, 1'b1);
        check("drop_next_seq", o_seq, 8'd2);
        recv_frame(want, 100, -1, -1, 23, "drop2", got, cyc);

        // Strobe held four cycles while the sink stalls: three drops.
        p = '{30'd100, 30'd50, 30'd150, 30'd100, 30'd99};
        exp_seq = exp_seq + 8'd1;
        make_frame(exp_seq, p, want);
        i_tx_ready = 1'b0;
        i_ph1 = p[0]; i_ph2 = p[1]; i_ph3 = p[2]; i_ph4 = p[3]; i_ph5 = p[4];
        i_ph_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        i_ph_en = 1'b0;
        check("hold_drop", o_drop_cnt, 8'd5);
        check("hold_seq", o_seq, exp_seq);
        recv_frame(want, 100, -1, -1, 23, "hold", got, cyc);

        // Saturation: 300 further drops while stalled.
        p = '{30'd1, 30'd2, 30'd3, 30'd4, 30'd5};
        exp_seq = exp_seq + 8'd1;
        make_frame(exp_seq, p, want);
        i_tx_ready = 1'b0;
        i_ph1 = p[0]; i_ph2 = p[1]; i_ph3 = p[2]; i_ph4 = p[3]; i_ph5 = p[4];
        i_ph_en = 1'b1;
        for (int i = 0; i < 301; i++) tick();
        i_ph_en = 1'b0;
        check("sat_drop", o_drop_cnt, 8'd255);
        recv_frame(want, 100, -1, -1, 23, "sat", got, cyc);
        check("sat_hold", o_drop_cnt, 8'd255);

        // 256 frames: sequence 1..255 then 0.
        i_res_n = 1'b0; tick(); i_res_n = 1'b1; exp_seq = 8'd0;
        check("seqrst_drop", o_drop_cnt, 8'd0);
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 5; k++) p[k] = 30'($urandom());
            exp_seq = exp_seq + 8'd1;
            make_frame(exp_seq, p, want);
            strobe(p);
            check($sformatf("seq_f%0d", f), o_seq, exp_seq);
            recv_frame(want, 100, -1, -1, 23, "seqw", got, cyc);
        end
        check("seq_wrap_zero", o_seq, 8'h00);
        check("seq_wrap_byte", got[1], 8'h00);

        // Reset asserted for one edge while byte 10 is presented.
        p = '{30'd42, 30'd40, 30'd44, 30'd42, 30'd0};
        exp_seq = exp_seq + 8'd1;
        make_frame(exp_seq, p, want);
        strobe(p);
        recv_frame(want, 100, -1, -1, 10, "pre_rst", got, cyc);
        check("pre_rst_valid", o_tx_valid, 1'b1);
        check("pre_rst_seq", o_seq, 8'd1);
        i_res_n = 1'b0;
        tick();
        check("mrst_valid", o_tx_valid, 1'b0);
        check("mrst_seq", o_seq, 8'h00);
        check("mrst_busy", o_busy, 1'b0);
        check("mrst_data", o_tx_data, 8'h00);
        i_res_n = 1'b1;
        tick(); tick();
        check("mrst_no_resume", o_tx_valid, 1'b0);
        exp_seq = 8'd1;
        make_frame(exp_seq, p, want);
        strobe(p);
        check("post_rst_seq", o_seq, 8'd1);
        recv_frame(want, 100, -1, -1, 23, "post_rst", got, cyc);
        check("post_rst_end", o_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
